// File: rtl/ext_mem_bus_arbiter.sv
// Round-robin arbiter sharing one native-bus slave among several native-bus masters.
// One grant per transaction, held until s_ready; includes a sticky busy-cycle watchdog.
module ext_mem_bus_arbiter #(
    parameter int N_MASTERS   = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256,
    localparam int GNT_W      = $clog2(N_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
    output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic                          s_valid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    output logic [GNT_W-1:0]              grant,
    output logic                          busy,
    output logic                          timeout
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state;
    logic [GNT_W-1:0] ptr;
    logic [GNT_W-1:0] next_grant;
    logic             found;
    logic             in_busy;
    int               idx;

    // Search starts at ptr and wraps, so the last served master goes to the back of the line.
    always_comb begin
        found      = 1'b0;
        next_grant = grant;
        idx        = 0;
        for (int k = 0; k < N_MASTERS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_MASTERS) begin
                idx = idx - N_MASTERS;
            end
            if (!found && m_valid[idx]) begin
                found      = 1'b1;
                next_grant = GNT_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant <= next_grant;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (s_ready) begin
                        state <= ST_IDLE;
                        ptr   <= (grant == GNT_W'(N_MASTERS - 1)) ? '0 : grant + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_busy = (state == ST_BUSY) && !rst;
    assign busy    = in_busy;
    assign s_valid = in_busy;

    // Slave-side request fields are forced to zero during reset, otherwise they track master[grant].
    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        if (!rst) begin
            s_addr  = m_addr[int'(grant)*ADDR_W +: ADDR_W];
            s_wdata = m_wdata[int'(grant)*DATA_W +: DATA_W];
            s_wstrb = m_wstrb[int'(grant)*STRB_W +: STRB_W];
        end
    end

    always_comb begin
        m_ready = '0;
        if (in_busy && s_ready) begin
            m_ready[grant] = 1'b1;
        end
    end

    assign m_rdata = {N_MASTERS{s_rdata}};

    generate
        if (TIMEOUT_CYC > 0) begin : g_wdog
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
            localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

            logic [CNT_W-1:0] cnt;
            logic             timeout_q;

            // Counts unanswered BUSY cycles; the flag is informational and never aborts the transfer.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt       <= '0;
                    timeout_q <= 1'b0;
                end else if (state == ST_IDLE && found) begin
                    cnt <= '0;
                end else if (state == ST_BUSY && !s_ready) begin
                    if (cnt == CNT_LAST) begin
                        timeout_q <= 1'b1;
                    end
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            assign timeout = timeout_q;
        end else begin : g_no_wdog
            assign timeout = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_ext_mem_bus_arbiter.sv
// Directed self-checking bench for ext_mem_bus_arbiter with two masters and an 8-cycle watchdog.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
module tb_ext_mem_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    m_valid;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*4-1:0]  m_wstrb;
    logic [N*DW-1:0] m_rdata;
    logic [N-1:0]    m_ready;
    logic            s_valid;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [3:0]      s_wstrb;
    logic [DW-1:0]   s_rdata;
    logic            s_ready;
    logic [0:0]      grant;
    logic            busy;
    logic            timeout;

    int checks = 0;
    int errors = 0;

    ext_mem_bus_arbiter #(
        .N_MASTERS  (N),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_valid(m_valid),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_wstrb(m_wstrb),
        .m_rdata(m_rdata),
        .m_ready(m_ready),
        .s_valid(s_valid),
        .s_addr (s_addr),
        .s_wdata(s_wdata),
        .s_wstrb(s_wstrb),
        .s_rdata(s_rdata),
        .s_ready(s_ready),
        .grant  (grant),
        .busy   (busy),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic sr);
        m_valid = v;
        s_ready = sr;
        #1;
    endtask

    task automatic doReset();
        rst     = 1'b1;
        m_valid = '0;
        s_ready = 1'b0;
        s_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        doReset();

        // Reset state
        applyStimulus(2'b00, 1'b0);
        checkOutput("rst_s_valid", 64'(s_valid), 64'd0);
        checkOutput("rst_busy",    64'(busy),    64'd0);
        checkOutput("rst_grant",   64'(grant),   64'd0);
        checkOutput("rst_timeout", 64'(timeout), 64'd0);
        checkOutput("rst_m_ready", 64'(m_ready), 64'd0);

        // Test 1: M0 write, slave answers on the 4th BUSY cycle
        m_addr[31:0]  = 32'h0000_0100;
        m_wdata[31:0] = 32'hDEAD_BEEF;
        m_wstrb[3:0]  = 4'hF;
        applyStimulus(2'b01, 1'b0);
        checkOutput("t1_idle_s_valid", 64'(s_valid), 64'd0);
        nextCycle();
        for (int b = 1; b <= 3; b++) begin
            applyStimulus(2'b01, 1'b0);
            checkOutput("t1_s_valid", 64'(s_valid), 64'd1);
            checkOutput("t1_m_ready", 64'(m_ready), 64'd0);
            if (b == 1) begin
                checkOutput("t1_s_addr",  64'(s_addr),  64'h100);
                checkOutput("t1_s_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
                checkOutput("t1_s_wstrb", 64'(s_wstrb), 64'hF);
                checkOutput("t1_grant",   64'(grant),   64'd0);
            end
            nextCycle();
        end
        applyStimulus(2'b01, 1'b1);
        checkOutput("t1_ready_m_ready", 64'(m_ready), 64'b01);
        nextCycle();
        applyStimulus(2'b00, 1'b0);
        checkOutput("t1_after_busy",    64'(busy),    64'd0);
        checkOutput("t1_after_m_ready", 64'(m_ready), 64'd0);

        // Test 6: s_ready while IDLE is ignored
        applyStimulus(2'b00, 1'b1);
        checkOutput("t6_m_ready", 64'(m_ready), 64'd0);
        nextCycle();
        applyStimulus(2'b00, 1'b1);
        checkOutput("t6_m_ready2", 64'(m_ready), 64'd0);
        checkOutput("t6_busy",     64'(busy),    64'd0);
        nextCycle();
        applyStimulus(2'b00, 1'b0);

        // Test 2: both masters read continuously, zero-wait slave; grants alternate with an IDLE gap
        doReset();
        m_wstrb = '0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 1'b0);
            checkOutput("t2_idle_gap", 64'(busy), 64'd0);
            nextCycle();
            applyStimulus(2'b11, 1'b1);
            checkOutput("t2_s_valid", 64'(s_valid), 64'd1);
            checkOutput("t2_grant",   64'(grant),   64'(i % 2));
            checkOutput("t2_m_ready", 64'(m_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
            nextCycle();
        end
        applyStimulus(2'b00, 1'b0);
        nextCycle();

        // Test 3: only M1 reads
        doReset();
        m_addr[63:32] = 32'h0000_0200;
        applyStimulus(2'b10, 1'b0);
        nextCycle();
        s_rdata = 32'h1234_5678;
        applyStimulus(2'b10, 1'b1);
        checkOutput("t3_grant",   64'(grant),          64'd1);
        checkOutput("t3_s_addr",  64'(s_addr),         64'h200);
        checkOutput("t3_m_ready", 64'(m_ready),        64'b10);
        checkOutput("t3_rdata1",  64'(m_rdata[63:32]), 64'h1234_5678);
        nextCycle();
        applyStimulus(2'b00, 1'b0);
        checkOutput("t3_after_m_ready", 64'(m_ready), 64'd0);

        // Test 4: watchdog trips after 8 unanswered BUSY cycles, late s_ready still completes
        doReset();
        m_addr[31:0] = 32'h0000_0300;
        applyStimulus(2'b01, 1'b0);
        nextCycle();
        for (int b = 1; b <= 8; b++) begin
            applyStimulus(2'b01, 1'b0);
            checkOutput("t4_no_timeout_yet", 64'(timeout), 64'd0);
            checkOutput("t4_s_valid",        64'(s_valid), 64'd1);
            nextCycle();
        end
        for (int b = 9; b <= 10; b++) begin
            applyStimulus(2'b01, 1'b0);
            checkOutput("t4_timeout",       64'(timeout), 64'd1);
            checkOutput("t4_s_valid_after", 64'(s_valid), 64'd1);
            nextCycle();
        end
        s_rdata = 32'hCAFE_F00D;
        applyStimulus(2'b01, 1'b1);
        checkOutput("t4_late_m_ready", 64'(m_ready),       64'b01);
        checkOutput("t4_late_rdata0",  64'(m_rdata[31:0]), 64'hCAFE_F00D);
        nextCycle();
        applyStimulus(2'b00, 1'b0);
        checkOutput("t4_idle_busy",      64'(busy),    64'd0);
        checkOutput("t4_timeout_sticky", 64'(timeout), 64'd1);

        // Test 5: asynchronous reset in the middle of a BUSY cycle
        doReset();
        m_addr[63:32] = 32'h0000_0200;
        applyStimulus(2'b10, 1'b0);
        nextCycle();
        applyStimulus(2'b10, 1'b1);
        checkOutput("t5_pre_m_ready", 64'(m_ready), 64'b10);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_s_valid", 64'(s_valid), 64'd0);
        checkOutput("t5_rst_m_ready", 64'(m_ready), 64'd0);
        checkOutput("t5_rst_busy",    64'(busy),    64'd0);
        checkOutput("t5_rst_s_addr",  64'(s_addr),  64'd0);
        checkOutput("t5_rst_grant",   64'(grant),   64'd0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(2'b11, 1'b0);
        checkOutput("t5_idle_busy", 64'(busy), 64'd0);
        nextCycle();
        applyStimulus(2'b11, 1'b1);
        checkOutput("t5_first_grant",   64'(grant),   64'd0);
        checkOutput("t5_first_m_ready", 64'(m_ready), 64'b01);
        nextCycle();
        applyStimulus(2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
